// File: rtl/sdram_if_pkg.sv
// Shared constants, FSM state encoding and burst types for the SDRAM write-port client.
package sdram_if_pkg;

  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned ADDR_W    = 24;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned CNT_W     = $clog2(BURST_LEN);

  localparam int unsigned FRAME_H   = 480;
  localparam int unsigned FRAME_V   = 272;
  localparam logic [ADDR_W-1:0] FRAME_WORDS_DEF = ADDR_W'(FRAME_H * FRAME_V);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } wr_state_t;

  // Word 0 is the first pixel of the burst.
  typedef logic [BURST_LEN-1:0][DATA_W-1:0] burst_t;

  function automatic logic is_last_burst(input logic [ADDR_W-1:0] ptr,
                                         input logic [ADDR_W-1:0] base,
                                         input logic [ADDR_W-1:0] words);
    return (ptr + ADDR_W'(BURST_LEN)) == (base + words);
  endfunction

endpackage

// File: rtl/sdram_burst_pack.sv
// Pixel-to-burst ping-pong packer: two 4-word banks with full flags, filled on the
// write side and released one at a time by the issue side.
module sdram_burst_pack
  import sdram_if_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              hold,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  input  logic              rel_rd,
  output logic              rd_full,
  output burst_t            rd_burst,
  output logic              any_full
);

  burst_t           bank [2];
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wr_sel;
  logic             rd_sel;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_word;

  assign pix_ready = en & ~full[wr_sel] & ~hold;
  assign accept    = pix_valid & pix_ready;
  assign last_word = accept & (cnt == CNT_W'(BURST_LEN - 1));

  // Fill and release always target different banks: a bank being released is full,
  // and a full bank cannot accept, so both updates can apply in the same cycle.
  always_comb begin
    full_nxt = full;
    if (rel_rd)
      full_nxt[rd_sel] = 1'b0;
    if (last_word)
      full_nxt[wr_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      cnt    <= '0;
    end else if (clr) begin
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      cnt    <= '0;
    end else begin
      full <= full_nxt;
      if (rel_rd)
        rd_sel <= ~rd_sel;
      if (accept) begin
        cnt <= last_word ? '0 : cnt + CNT_W'(1);
        if (last_word)
          wr_sel <= ~wr_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < 2; b++)
        bank[b] <= '0;
    end else if (accept && !clr) begin
      bank[wr_sel][cnt] <= pix_data;
    end
  end

  assign rd_full  = full[rd_sel];
  assign rd_burst = bank[rd_sel];
  assign any_full = |full;

endmodule

// File: rtl/sdram_burst_writer.sv
// SDRAM arbiter write-port client: packs pixels into 4-word bursts, walks the frame
// address range and handshakes Wr_Req/Wr_Done. Optional watchdog: SDRAM_WR_TIMEOUT_EN.
module sdram_burst_writer
  import sdram_if_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter logic [23:0] FRAME_WORDS = FRAME_WORDS_DEF,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        iStart,
  input  logic        iPix_Valid,
  input  logic [15:0] iPix_Data,
  output logic        oPix_Ready,
  output logic        oWr_Req,
  output logic [23:0] oWr_Addr,
  output logic [15:0] oWr_Data1,
  output logic [15:0] oWr_Data2,
  output logic [15:0] oWr_Data3,
  output logic [15:0] oWr_Data4,
  input  logic        iWr_Done,
  output logic        oFrame_Done,
  output logic        oBusy,
  output logic        oErr
);

  wr_state_t         state;
  wr_state_t         state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              start_pending;
  logic              frame_done_q;
  burst_t            data_q;
  logic              rd_full;
  burst_t            rd_burst;
  logic              any_full;
  logic              last_burst;
  logic              timeout_ev;

  logic              issue;
  logic              finish;
  logic              clr;

  assign last_burst = is_last_burst(ptr, BASE_ADDR, FRAME_WORDS);

  sdram_burst_pack u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (en),
    .hold      (start_pending),
    .pix_valid (iPix_Valid),
    .pix_data  (iPix_Data),
    .pix_ready (oPix_Ready),
    .rel_rd    (finish),
    .rd_full   (rd_full),
    .rd_burst  (rd_burst),
    .any_full  (any_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (issue)  state_nxt = S_REQ;
      S_REQ:   if (finish) state_nxt = S_GAP;
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A restart seen while idle clears at once; one arriving mid-request is deferred to
  // the gap cycle so the in-flight burst lands at its original address.
  always_comb begin
    oWr_Req = 1'b0;
    issue   = 1'b0;
    finish  = 1'b0;
    clr     = 1'b0;
    unique case (state)
      S_IDLE: begin
        clr   = iStart;
        issue = rd_full & en & ~iStart;
      end
      S_REQ: begin
        oWr_Req = 1'b1;
        finish  = iWr_Done | timeout_ev;
      end
      S_GAP: begin
        clr = start_pending | iStart;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= BASE_ADDR;
      start_pending <= 1'b0;
      frame_done_q  <= 1'b0;
      oWr_Addr      <= BASE_ADDR;
      data_q        <= '0;
    end else begin
      frame_done_q <= finish & last_burst;
      if (clr) begin
        ptr           <= BASE_ADDR;
        start_pending <= 1'b0;
      end else begin
        if (finish)
          ptr <= last_burst ? BASE_ADDR : ptr + ADDR_W'(BURST_LEN);
        if (iStart && state == S_REQ)
          start_pending <= 1'b1;
      end
      if (issue) begin
        oWr_Addr <= ptr;
        data_q   <= rd_burst;
      end
    end
  end

`ifdef SDRAM_WR_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        err_q;

  assign timeout_ev = (state == S_REQ) & ~iWr_Done & (to_cnt == TIMEOUT_CYC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= (state == S_REQ && !finish) ? to_cnt + 16'd1 : '0;
      if (timeout_ev)
        err_q <= 1'b1;
    end
  end

  assign oErr = err_q;
`else
  assign timeout_ev = 1'b0;
  assign oErr       = 1'b0 & (TIMEOUT_CYC != '0);
`endif

  assign oWr_Data1   = data_q[0];
  assign oWr_Data2   = data_q[1];
  assign oWr_Data3   = data_q[2];
  assign oWr_Data4   = data_q[3];
  assign oFrame_Done = frame_done_q;
  assign oBusy       = any_full | oWr_Req;

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Scoreboard bench for sdram_burst_writer: accepted pixels form expected bursts,
// a responder model acknowledges requests and a monitor checks what the DUT issues.
module tb_sdram_burst_writer;

  localparam logic [23:0] BASE  = 24'h000000;
  localparam logic [23:0] FRAME = 24'd32;
  localparam logic [23:0] LAST  = BASE + FRAME - 24'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        iStart = 1'b0;
  logic        iPix_Valid = 1'b0;
  logic [15:0] iPix_Data = '0;
  logic        iWr_Done = 1'b0;
  logic        oPix_Ready, oWr_Req, oFrame_Done, oBusy, oErr;
  logic [23:0] oWr_Addr;
  logic [15:0] oWr_Data1, oWr_Data2, oWr_Data3, oWr_Data4;

  sdram_burst_writer #(
    .BASE_ADDR   (BASE),
    .FRAME_WORDS (FRAME),
    .TIMEOUT_CYC (16'd1023)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .iStart      (iStart),
    .iPix_Valid  (iPix_Valid),
    .iPix_Data   (iPix_Data),
    .oPix_Ready  (oPix_Ready),
    .oWr_Req     (oWr_Req),
    .oWr_Addr    (oWr_Addr),
    .oWr_Data1   (oWr_Data1),
    .oWr_Data2   (oWr_Data2),
    .oWr_Data3   (oWr_Data3),
    .oWr_Data4   (oWr_Data4),
    .iWr_Done    (iWr_Done),
    .oFrame_Done (oFrame_Done),
    .oBusy       (oBusy),
    .oErr        (oErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] addr;
    logic [63:0] data;
  } burst_exp_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [15:0] pix_q[$];
  burst_exp_t  exp_q[$];
  int unsigned burst_idx = 0;
  int unsigned acc_cnt = 0;
  int unsigned dones = 0;
  int unsigned fd_seen = 0;
  int unsigned fd_exp = 0;
  int unsigned arb_delay = 2;
  bit          arb_rand = 1'b0;
  bit          start_in_flight = 1'b0;
  bit          stray_done_req = 1'b0;
  bit          prev_req = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected burst k after a restart lands at BASE + 4*(k mod bursts-per-frame).
  function automatic logic [23:0] model_addr(input int unsigned k);
    return BASE + 24'((k % (int'(FRAME) / 4)) * 4);
  endfunction

  always @(negedge clk) begin : scoreboard
    burst_exp_t b;
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (iPix_Valid && oPix_Ready) begin
        acc_cnt++;
        pix_q.push_back(iPix_Data);
        if (pix_q.size() == 4) begin
          b.addr = model_addr(burst_idx);
          b.data = {pix_q[3], pix_q[2], pix_q[1], pix_q[0]};
          exp_q.push_back(b);
          pix_q.delete();
          burst_idx++;
        end
      end
      if (oWr_Req && !prev_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", {40'd0, oWr_Addr}, 64'hFFFF_FFFF);
        end else begin
          b = exp_q.pop_front();
          check("burst_addr", {40'd0, oWr_Addr}, {40'd0, b.addr});
          check("burst_data", {oWr_Data4, oWr_Data3, oWr_Data2, oWr_Data1}, b.data);
        end
      end
      prev_req = oWr_Req;
      if (oFrame_Done) fd_seen++;
    end
  end

  initial begin : responder
    logic [23:0] a;
    int unsigned d;
    forever begin
      @(negedge clk);
      if (rst_n && oWr_Req) begin
        a = oWr_Addr;
        d = arb_rand ? $urandom_range(0, 6) : arb_delay;
        for (int i = 0; i < int'(d); i++) begin
          @(negedge clk);
          check("req_held", {39'd0, oWr_Req, oWr_Addr}, {39'd0, 1'b1, a});
        end
        @(posedge clk); #1 iWr_Done = 1'b1;
        @(posedge clk); #1 iWr_Done = 1'b0;
        @(negedge clk);
        check("req_drop", {63'd0, oWr_Req}, 64'd0);
        check("frame_done", {63'd0, oFrame_Done}, {63'd0, (a == LAST)});
        if (a == LAST) fd_exp++;
        check("ready_after_done", {63'd0, oPix_Ready}, {63'd0, (en && !start_in_flight)});
        start_in_flight = 1'b0;
        dones++;
      end else if (rst_n && stray_done_req) begin
        @(posedge clk); #1 iWr_Done = 1'b1;
        @(posedge clk); #1 iWr_Done = 1'b0;
        stray_done_req = 1'b0;
      end
    end
  end

  task automatic send_pixel(input logic [15:0] d);
    int unsigned t = 0;
    iPix_Valid = 1'b1;
    iPix_Data  = d;
    @(negedge clk);
    while (!oPix_Ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("pix_accept_timeout", 64'(t), 64'd0);
    @(posedge clk); #1 iPix_Valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    while ((exp_q.size() != 0 || oBusy || oWr_Req) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain_in_time", {63'd0, (t < 1000)}, 64'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input bit in_flight);
    @(posedge clk); #1;
    iStart = 1'b1;
    start_in_flight = in_flight;
    burst_idx = 0;
    pix_q.delete();
    @(posedge clk); #1 iStart = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    int unsigned t;
    int unsigned acc0;
    int unsigned d0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req",   {63'd0, oWr_Req},     64'd0);
    check("rst_addr",  {40'd0, oWr_Addr},    {40'd0, BASE});
    check("rst_data",  {oWr_Data4, oWr_Data3, oWr_Data2, oWr_Data1}, 64'd0);
    check("rst_fdone", {63'd0, oFrame_Done}, 64'd0);
    check("rst_busy",  {63'd0, oBusy},       64'd0);
    check("rst_err",   {63'd0, oErr},        64'd0);
    check("rst_ready", {63'd0, oPix_Ready},  64'd0);
    @(posedge clk); #1 rst_n = 1'b1; en = 1'b1;

    // First burst and its issue latency
    arb_delay = 3;
    send_pixel(16'h1111);
    send_pixel(16'h2222);
    send_pixel(16'h3333);
    send_pixel(16'h4444);
    @(negedge clk);
    check("req_latency_edge_n",  {63'd0, oWr_Req}, 64'd0);
    @(negedge clk);
    check("req_latency_edge_n1", {63'd0, oWr_Req}, 64'd1);
    drain();

    pulse_start(1'b0);

    // Both banks fill while the first burst waits on a slow done
    arb_delay = 20;
    acc0 = acc_cnt;
    d0 = dones;
    fork
      begin
        for (int i = 0; i < 12; i++) send_pixel(16'($urandom));
      end
      begin
        t = 0;
        while (!iWr_Done && t < 200) begin
          @(negedge clk);
          t++;
        end
        check("stall_accepts", 64'(acc_cnt - acc0), 64'd8);
        check("stall_ready",   {63'd0, oPix_Ready}, 64'd0);
      end
    join
    drain();
    check("three_bursts", 64'(dones - d0), 64'd3);

    // A done pulse with nothing outstanding must not move the address
    stray_done_req = 1'b1;
    t = 0;
    while (stray_done_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;

    // Restart while a request is in flight at 0x10
    arb_delay = 2;
    for (int i = 0; i < 4; i++) send_pixel(16'($urandom));
    drain();
    arb_delay = 15;
    for (int i = 0; i < 4; i++) send_pixel(16'($urandom));
    t = 0;
    while (!oWr_Req && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("inflight_addr", {40'd0, oWr_Addr}, 64'h10);
    pulse_start(1'b1);
    iPix_Valid = 1'b1;
    iPix_Data  = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ready_start_pending", {62'd0, oWr_Req, oPix_Ready}, 64'd2);
    end
    for (int i = 0; i < 4; i++) send_pixel(16'($urandom));
    drain();

    // Enable dropped while a request is outstanding and another bank is full
    arb_delay = 12;
    for (int i = 0; i < 8; i++) send_pixel(16'($urandom));
    @(posedge clk); #1 en = 1'b0;
    d0 = dones;
    t = 0;
    while (dones == d0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("en0_done_taken", 64'(dones - d0), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("en0_no_req", {62'd0, oWr_Req, oPix_Ready}, 64'd0);
    end
    @(posedge clk); #1 en = 1'b1;
    drain();

    // Randomised traffic across frame wraps
    arb_rand = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 en = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      send_pixel(16'($urandom));
    end
    drain();

    check("frame_done_count", 64'(fd_seen), 64'(fd_exp));
    check("frame_done_seen",  {63'd0, (fd_seen >= 2)}, 64'd1);
    check("no_leftover_pix",  64'(pix_q.size()), 64'd0);
    check("final_busy",       {63'd0, oBusy}, 64'd0);
    check("final_err",        {63'd0, oErr},  64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
